// File: rtl/digit_serial_subtractor_pkg.sv
// Shared types for the digit-serial subtractor.
// Latency: n/a (types only).
// Backpressure: n/a.
package sub_pkg;

  // Operation sequencing: wait for operands, grind digits, present result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Status flags reported alongside the difference word.
  typedef struct packed {
    logic bout;
    logic zero;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/digit_serial_subtractor_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface digit_serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  // Producer/consumer side that drives operands and accepts results.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/digit_serial_subtractor_digit_sub.sv
// One DIGIT-wide ripple-borrow subtract stage built from full-subtractor cells.
// Latency: combinational.
// Backpressure: none.
module digit_sub #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  // Ripple the borrow from LSB to MSB through per-bit full subtractors.
  always_comb begin
    logic br;
    d  = '0;
    br = bin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a_d[i] ^ b_d[i] ^ br;
      br   = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/digit_serial_subtractor.sv
// Computes A - B - bin over WIDTH bits, DIGIT bits per clock, with borrow/zero/ovf flags.
// Latency: NDIG cycles from accept to out_valid; one op per NDIG+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module digit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  digit_serial_subtractor_if.slave s_if
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  flags_t           r_flags;

  logic [DIGIT-1:0] w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_next_diff;

  digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
    .a_d  (r_a[DIGIT-1:0]),
    .b_d  (r_b[DIGIT-1:0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // New digit enters at the top so the word is aligned after NDIG shifts.
  if (NDIG == 1) begin : g_one_digit
    assign w_next_diff = w_d;
  end else begin : g_multi_digit
    assign w_next_diff = {w_d, r_diff[WIDTH-1:DIGIT]};
  end

  // Sequencer, operand shifters, borrow chain and flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_a      <= s_if.a;
            r_b      <= s_if.b;
            r_borrow <= s_if.bin;
            r_a_msb  <= s_if.a[WIDTH-1];
            r_b_msb  <= s_if.b[WIDTH-1];
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff   <= w_next_diff;
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(NDIG - 1)) begin
            r_flags.bout <= w_bout;
            r_flags.zero <= (w_next_diff == '0);
            r_flags.ovf  <= (r_a_msb != r_b_msb) && (w_next_diff[WIDTH-1] != r_a_msb);
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (s_if.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_if.in_ready  = (r_state == IDLE);
  assign s_if.out_valid = (r_state == DONE);
  assign s_if.diff      = r_diff;
  assign s_if.bout      = r_flags.bout;
  assign s_if.zero      = r_flags.zero;
  assign s_if.ovf       = r_flags.ovf;

endmodule

// File: doc/digit_serial_subtractor.md
# digit_serial_subtractor

Parametrised multi-bit subtractor that computes A − B − Bin over a WIDTH-bit word, DIGIT bits per clock, with a ripple borrow carried between cycles in a register. It generalises the single-bit full-subtractor cell to arbitrary word widths and adds unsigned-borrow, zero and signed-overflow flags. It uses valid/ready handshakes on both sides and sits in the datapath wherever area matters more than single-cycle latency.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 4, bits processed per cycle.
- WIDTH % DIGIT != 0 is an elaboration error.
- NDIG = WIDTH/DIGIT (derived local constant).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands and bin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  A − B − bin, modulo 2^WIDTH.
- bout  out  1  final borrow; set when unsigned A < B + bin.
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

## Operation
FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: capture a, b and bin into shift registers. Load the borrow register with bin. Clear the digit counter. Go to RUN.
- **RUN**
  - in_ready = 0.
  - Each cycle, subtract the low DIGIT bits of the B shift register and the borrow register from the low DIGIT bits of the A shift register.
  - Shift the result digit into the top of the diff register (LSB digit first, so after NDIG shifts the word is aligned).
  - Shift the A and B registers right by DIGIT. Update the borrow register. Increment the counter.
  - When the counter reaches NDIG−1 and that digit is processed, go to DONE.
- **DONE**
  - out_valid = 1. diff, bout, zero and ovf are stable.
  - On out_ready: go to IDLE. No new accept happens in the same cycle.
- in_valid is ignored outside IDLE.
- in_valid is ignored while rst is high.
- Arithmetic:
  - Each digit is computed at DIGIT+1 bits. The borrow out is the top bit of (a_d − b_d − borrow).
  - zero and ovf are registered at the transition into DONE.
- Reset values (after the reset edge):
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - diff = 0, bout = 0, zero = 0, ovf = 0.
  - Counter and borrow register = 0.
- Reset mid-RUN or mid-DONE aborts the operation. No result is emitted and the partial diff is discarded.
- Outputs diff and the flags hold their last values in IDLE. They are only meaningful while out_valid = 1.

## Timing
- Latency: accept at edge k; out_valid is high in the cycle after edge k+NDIG, i.e. NDIG cycles after accept.
- With out_ready held high, throughput is one operation per NDIG+2 cycles.
- DIGIT == WIDTH gives NDIG = 1: one RUN cycle and latency 1.
- Backpressure: DONE holds indefinitely. out_valid, diff and flags stay constant until out_ready is seen.
- in_ready is a combinational decode of state == IDLE. out_valid is a decode of state == DONE. Neither output depends on an input in the same cycle.
- If rst and in_valid are high in the same cycle, reset wins and nothing is captured.

## Structure
- Package sub_pkg:
  - State typedef: IDLE, RUN, DONE.
  - Flags struct: bout, zero, ovf.
- Sub-module digit_sub:
  - Combinational, DIGIT-wide ripple-borrow stage.
  - Inputs: a_d, b_d, bin. Outputs: d, bout.
  - Built from per-bit full-subtractor equations: d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
- Top level holds the FSM, counter, shift registers and flag logic.

## Test plan
All scenarios use WIDTH=32, DIGIT=4 unless noted.
1. a=0x00000005, b=0x00000003, bin=0 → after 8 cycles out_valid=1, diff=0x00000002, bout=0, zero=0, ovf=0.
2. a=0x00000000, b=0x00000001, bin=0 → diff=0xFFFFFFFF, bout=1, ovf=0.
3. a=0x80000000, b=0x00000001, bin=0 → diff=0x7FFFFFFF, ovf=1, bout=0.
4. a=0x00000007, b=0x00000006, bin=1 → diff=0, zero=1, bout=0.
5. Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid → out_valid stays 1, diff is stable, in_ready=0, and the extra operands are never accepted.
6. Assert rst in RUN cycle 3 → next cycle out_valid=0, in_ready=1, and no result is ever emitted. Repeat with WIDTH=DIGIT=8: a=0x10, b=0x20 → diff=0xF0, bout=1, one cycle after accept.
